// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - ALU control codes and execute-unit FSM state type
package alu_exec_pkg;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_SRL = 4'd2;
   localparam logic [3:0] ALU_SLL = 4'd3;
   localparam logic [3:0] ALU_MUL = 4'd4;
   localparam logic [3:0] ALU_AND = 4'd5;
   localparam logic [3:0] ALU_XOR = 4'd6;
   localparam logic [3:0] ALU_OR  = 4'd7;
   localparam logic [3:0] ALU_SLA = 4'd8;
   localparam logic [3:0] ALU_SRA = 4'd9;
   localparam logic [3:0] ALU_SLT = 4'd10;
   localparam logic [3:0] ALU_MOV = 4'd11;
   localparam logic [3:0] ALU_SGT = 4'd12;
   localparam logic [3:0] ALU_SLE = 4'd13;
   localparam logic [3:0] ALU_SNE = 4'd14;
   localparam logic [3:0] ALU_SEQ = 4'd15;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/alu_seq_multiplier.sv
// rtl/alu_seq_multiplier.sv - shift-add multiplier, one multiplier bit per cycle
// ALU_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier is zero.
module alu_seq_multiplier #(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             busy
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplr_q, mplr_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;

   // done is asserted during the final iteration so the caller can register acc_d directly
   always_comb begin
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done    = 1'b0;
      if (busy_q) begin
         acc_d   = acc_q + (mplr_q[0] ? mcand_q : '0);
         mcand_d = mcand_q << 1;
         mplr_d  = mplr_q >> 1;
         cnt_d   = cnt_q + CW'(1);
`ifdef ALU_MUL_EARLY_EXIT_EN
         done    = (cnt_q == LAST) || (mplr_d == '0);
`else
         done    = (cnt_q == LAST);
`endif
         if (done) begin
            busy_d = 1'b0;
         end
      end else if (start) begin
         mcand_d = a;
         mplr_d  = b;
         acc_d   = '0;
         cnt_d   = '0;
         busy_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   assign product = acc_d;
   assign busy    = busy_q;

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - ALU execute stage: decode, single-cycle datapath, MUL FSM, result register
// ALU_MUL_EARLY_EXIT_EN selects early-exit multiplication in alu_seq_multiplier.
module alu_exec_unit
   import alu_exec_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [3:0]       alu_ctl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy
);

   state_t           state_q, state_d;
   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;

   logic             accept;
   logic             is_mul;
   logic             mul_done;
   logic             mul_busy;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH-1:0] alu_y;
   logic [SHW-1:0]   shamt;

   function automatic logic [WIDTH-1:0] flag(input logic c);
      return {{(WIDTH-1){1'b0}}, c};
   endfunction

   assign shamt    = b[SHW-1:0];
   assign is_mul   = (alu_ctl == ALU_MUL);
   assign op_ready = (state_q == IDLE) && (!res_valid_q || res_ready);
   assign accept   = op_valid && op_ready;

   always_comb begin
      alu_y = '0;
      case (alu_ctl)
         ALU_ADD: alu_y = a + b;
         ALU_SUB: alu_y = a - b;
         ALU_SRL: alu_y = a >> shamt;
         ALU_SLL: alu_y = a << shamt;
         ALU_AND: alu_y = a & b;
         ALU_XOR: alu_y = a ^ b;
         ALU_OR:  alu_y = a | b;
         ALU_SLA: alu_y = a << shamt;
         ALU_SRA: alu_y = $unsigned($signed(a) >>> shamt);
         ALU_SLT: alu_y = flag($signed(a) < $signed(b));
         ALU_MOV: alu_y = a;
         ALU_SGT: alu_y = flag($signed(a) > $signed(b));
         ALU_SLE: alu_y = flag($signed(a) <= $signed(b));
         ALU_SNE: alu_y = flag(a != b);
         ALU_SEQ: alu_y = flag(a == b);
         default: alu_y = '0;
      endcase
   end

   alu_seq_multiplier #(
      .WIDTH (WIDTH),
      .CW    (SHW)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (accept && is_mul),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product),
      .busy    (mul_busy)
   );

   // a drain and a new result on the same edge leave res_valid set
   always_comb begin
      state_d     = state_q;
      res_valid_d = res_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_mul) begin
                  state_d = MUL;
               end else begin
                  result_d    = alu_y;
                  zero_d      = (alu_y == '0);
                  res_valid_d = 1'b1;
               end
            end
         end
         MUL: begin
            if (mul_done) begin
               result_d    = mul_product;
               zero_d      = (mul_product == '0);
               res_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         res_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         res_valid_q <= res_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
      end
   end

   assign res_valid = res_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign busy      = mul_busy;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit (honours ALU_MUL_EARLY_EXIT_EN)
module tb_alu_exec_unit;
   import alu_exec_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        op_valid = 1'b0;
   logic        res_ready = 1'b1;
   logic [3:0]  alu_ctl = 4'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        op_ready;
   logic        res_valid;
   logic [31:0] result;
   logic        zero;
   logic        busy;

   int          errors = 0;
   int          checks = 0;
   logic [32:0] exp_q[$];

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .alu_ctl   (alu_ctl),
      .a         (a),
      .b         (b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .result    (result),
      .zero      (zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: pops one expectation per result transfer
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got %h expected none", result);
            end else begin
               e = exp_q.pop_front();
               check("result", result, e[31:0]);
               check("zero", {31'b0, zero}, {31'b0, e[32]});
            end
         end
      end
   end

   // called just after a falling edge; returns on the falling edge after the accept edge
   task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input bit push);
      int t;
      t = 0;
      op_valid = 1'b1;
      alu_ctl  = c;
      a        = x;
      b        = y;
      while (!op_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!op_ready) begin
         checks++;
         errors++;
         $display("FAIL op_ready_timeout: got 0 expected 1");
         op_valid = 1'b0;
      end else begin
         @(posedge clk);
         if (push) exp_q.push_back({(er == 32'd0), er});
         #1 op_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      int t;

      repeat (2) @(negedge clk);
      check("rst_res_valid", {31'b0, res_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_zero", {31'b0, zero}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_op_ready", {31'b0, op_ready}, 32'd1);

      issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
      check("add_latency", {31'b0, res_valid}, 32'd1);
      issue(ALU_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b1);
      issue(ALU_SRL, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b1);
      issue(ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b1);
      issue(ALU_SLL, 32'd3, 32'h0000_0104, 32'h0000_0030, 1'b1);
      issue(ALU_SLA, 32'd3, 32'd4, 32'h0000_0030, 1'b1);
      issue(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b1);
      issue(ALU_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b1);
      issue(ALU_OR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b1);
      issue(ALU_MOV, 32'h1234_5678, 32'd9, 32'h1234_5678, 1'b1);
      issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1);
      issue(ALU_SGT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
      issue(ALU_SLE, 32'd5, 32'd5, 32'd1, 1'b1);
      issue(ALU_SNE, 32'd5, 32'd5, 32'd0, 1'b1);
      issue(ALU_SEQ, 32'd5, 32'd5, 32'd1, 1'b1);

      // multiplier latency counted from the accept cycle
      issue(ALU_MUL, 32'd7, 32'd6, 32'd42, 1'b1);
      check("mul_busy", {31'b0, busy}, 32'd1);
      n = 0;
      while (!res_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
`ifdef ALU_MUL_EARLY_EXIT_EN
      check("mul_latency", n + 1, 32'd4);
`else
      check("mul_latency", n + 1, 32'd33);
`endif
      check("mul_busy_done", {31'b0, busy}, 32'd0);
      issue(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b1);
      issue(ALU_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1);
      issue(ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b1);

      // output stall, then drain and accept on the same edge
      t = 0;
      while (res_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      res_ready = 1'b0;
      issue(ALU_ADD, 32'd10, 32'd5, 32'd15, 1'b1);
      check("stall_op_ready", {31'b0, op_ready}, 32'd0);
      op_valid = 1'b1;
      alu_ctl  = ALU_XOR;
      a        = 32'h0000_F0F0;
      b        = 32'h0000_FF00;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_result", result, 32'd15);
      end
      check("stall_res_valid", {31'b0, res_valid}, 32'd1);
      res_ready = 1'b1;
      #1;
      check("drain_op_ready", {31'b0, op_ready}, 32'd1);
      @(posedge clk);
      exp_q.push_back({1'b0, 32'h0000_0FF0});
      #1 op_valid = 1'b0;
      @(negedge clk);
      check("drain_accept_valid", {31'b0, res_valid}, 32'd1);

      // reset in the middle of a multiply
      issue(ALU_MUL, 32'd7, 32'hFFFF_FFFF, 32'd0, 1'b0);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_res_valid", {31'b0, res_valid}, 32'd0);
      check("abort_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(ALU_MUL, 32'd3, 32'd3, 32'd9, 1'b1);

      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("scoreboard_drained", exp_q.size(), 32'd0);
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
